core_fetch_queue: RTL and testbench

Parametrised instruction-fetch front end that replaces the fixed three-entry prefetch path. It issues sequential word requests to a one-cycle-latency IMEM, buffers returned instructions with their PCs in a DEPTH-entry queue, and hands them to decode under a valid/ready handshake. Redirects flush the queue and discard stale responses. The block sits between the IMEM port and the IF/ID pipeline register.

---
 rtl/core_fetch_pkg.sv | 19 +
 rtl/core_fetch_queue_if.sv | 37 +++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/core_fetch_queue.sv | 123 ++++++++++++
 tb/tb_core_fetch_queue.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_fetch_pkg.sv
// core_fetch_pkg: shared types and constants for the instruction-fetch front end.
// A queue entry pairs an instruction word with the PC it was fetched from.
package core_fetch_pkg;

    // Word width that the entry layout below is built for.
    localparam int FETCH_XLEN = 32;

    // Canonical RISC-V NOP (addi x0, x0, 0), driven while no instruction is valid.
    localparam logic [FETCH_XLEN-1:0] FETCH_NOP_INSTR = 32'h0000_0013;

    // Default first fetch address after reset.
    localparam logic [FETCH_XLEN-1:0] FETCH_RESET_PC = 32'h1000_0000;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/core_fetch_queue_if.sv
// core_fetch_queue_if: IMEM request/response port plus the decode-side
// valid/ready handshake. Signal suffixes are from the fetch queue's viewpoint;
// the fetch queue binds the master modport, IMEM/decode bind the slave modport.
interface core_fetch_queue_if #(
    parameter int XLEN = 32
);
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_rvalid_i;
    logic [XLEN-1:0] imem_rdata_i;
    logic            instr_valid_o;
    logic [XLEN-1:0] instr_o;
    logic [XLEN-1:0] pc_instr_o;
    logic            instr_ready_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_rvalid_i,
        input  imem_rdata_i,
        output instr_valid_o,
        output instr_o,
        output pc_instr_o,
        input  instr_ready_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_rvalid_i,
        output imem_rdata_i,
        input  instr_valid_o,
        input  instr_o,
        input  pc_instr_o,
        output instr_ready_i
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: generic DEPTH-entry synchronous FIFO with wrap-around pointers,
// a synchronous flush that empties it in one cycle, and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full;

    // Pointer and occupancy bookkeeping; flush outranks push and pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Entry storage write.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is deliberately not reset; the count alone decides which entries are live.
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));

    // Overflow would mean the upstream credit check is broken.
    assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && !pop_i && !flush_i && full))
        else $error("fetch_fifo: push while full");

endmodule

// File: rtl/core_fetch_queue.sv
// core_fetch_queue: instruction-fetch front end. Issues sequential word
// requests to a one-cycle-latency IMEM, buffers {pc, instr} in a DEPTH-entry
// queue and presents the head to decode under valid/ready. A redirect flushes
// the queue and discards any stale response.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN -- a response arriving while
// the queue is empty drives the outputs combinationally in the same cycle.
module core_fetch_queue
    import core_fetch_pkg::*;
#(
    parameter int              XLEN      = FETCH_XLEN,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] RESET_PC  = FETCH_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = FETCH_NOP_INSTR
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic [XLEN-1:0]        flush_pc_i,
    input  logic                   dma_stall_i,
    core_fetch_queue_if.master     bus,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = $bits(fetch_entry_t);

    logic [XLEN-1:0] pc_fetch_q, pc_fetch_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    logic            drop_q, drop_d;

    logic            credit_ok;
    logic            req;
    logic            resp_accept;
    logic            bypass_hit;
    logic            head_valid;
    logic            pop;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    fetch_entry_t    resp_entry;
    fetch_entry_t    fifo_rdata;
    fetch_entry_t    head;

    // A request is only issued if its response is guaranteed a free slot.
    assign credit_ok = (fifo_count + CW'(inflight_q)) < CW'(DEPTH);
    assign req       = !rst_i && !flush_i && !dma_stall_i && credit_ok;

    // A response is only meaningful if we asked for it and it is not stale.
    assign resp_accept = bus.imem_rvalid_i && inflight_q && !drop_q && !flush_i;
    assign resp_entry  = '{pc: inflight_pc_q, instr: bus.imem_rdata_i};

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_hit = resp_accept && fifo_empty;
    assign head       = fifo_empty ? resp_entry : fifo_rdata;
    // A bypassed response consumed by decode never needs to be stored.
    assign fifo_push  = resp_accept && !(bypass_hit && bus.instr_ready_i);
    assign fifo_pop   = pop && !fifo_empty;
`else
    assign bypass_hit = 1'b0;
    assign head       = fifo_rdata;
    assign fifo_push  = resp_accept;
    assign fifo_pop   = pop;
`endif

    assign head_valid = !fifo_empty || bypass_hit;
    assign pop        = head_valid && bus.instr_ready_i && !flush_i;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (fifo_push),
        .wdata_i (resp_entry),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    // Next fetch PC, in-flight tracking and stale-response drop flag.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        pc_fetch_d    = pc_fetch_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = req;
        drop_d        = 1'b0;
        if (flush_i) begin
            pc_fetch_d = flush_pc_i & ~XLEN'(3);
            drop_d     = inflight_q;
        end else if (req) begin
            pc_fetch_d    = pc_fetch_q + XLEN'(4);
            inflight_pc_d = pc_fetch_q;
        end
    end

    // Fetch-side state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_fetch_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            pc_fetch_q    <= pc_fetch_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            drop_q        <= drop_d;
        end
    end

    // Address is held low when idle so every output is quiet in reset.
    assign bus.imem_req_o    = req;
    assign bus.imem_addr_o   = req ? pc_fetch_q : '0;
    assign bus.instr_valid_o = head_valid;
    assign bus.instr_o       = head_valid ? head.instr : NOP_INSTR;
    assign bus.pc_instr_o    = head_valid ? head.pc : '0;
    assign count_o           = fifo_count;

endmodule

// File: tb/tb_core_fetch_queue.sv
// tb_core_fetch_queue: self-checking bench for core_fetch_queue. An IMEM model
// answers each request one cycle later with addr ^ 32'hA5A5_0000. A queue-based
// reference model predicts every output each cycle; directed sequences cover
// start-up, back-pressure, redirect, DMA stall, address wrap and async reset.
module tb_core_fetch_queue;
    import core_fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam int          CW       = $clog2(DEPTH) + 1;
    localparam logic [31:0] RESET_PC = 32'h1000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int LAT = BYP ? 1 : 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          flush_i;
    logic [31:0]   flush_pc_i;
    logic          dma_stall_i;
    logic [CW-1:0] count_o;

    core_fetch_queue_if #(.XLEN(32)) bus ();

    core_fetch_queue #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .flush_pc_i  (flush_pc_i),
        .dma_stall_i (dma_stall_i),
        .bus         (bus),
        .count_o     (count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        bit          rdy;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        int          e_count;
    } vec_t;

    // Reference model state
    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_inflight_pc;
    bit          m_inflight;
    bit          m_drop;

    // IMEM model: remembers the request seen last cycle
    bit          prev_req;
    logic [31:0] prev_addr;

    // Values sampled in the most recent cycle
    logic          s_req, s_valid;
    logic [31:0]   s_addr, s_pc, s_instr;
    logic [CW-1:0] s_count;

    logic [31:0] pop_log[$];
    vec_t        tbl[6];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] a0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc          = RESET_PC;
        m_inflight_pc = '0;
        m_inflight    = 1'b0;
        m_drop        = 1'b0;
        prev_req      = 1'b0;
        prev_addr     = '0;
        pop_log.delete();
    endtask

    // One clock cycle: called at a negedge, returns at the next negedge.
    task automatic cycle(input bit fl, input logic [31:0] fpc, input bit st,
                         input bit rdy, input bit spur);
        bit          rv, e_req, accept, hv, from_resp, popped;
        logic [31:0] rdata;
        ent_t        head, resp;

        rv    = prev_req | spur;
        rdata = prev_req ? (prev_addr ^ KEY) : $urandom;
        flush_i           = fl;
        flush_pc_i        = fpc;
        dma_stall_i       = st;
        bus.instr_ready_i = rdy;
        bus.imem_rvalid_i = rv;
        bus.imem_rdata_i  = rdata;
        #1;
        s_req   = bus.imem_req_o;
        s_addr  = bus.imem_addr_o;
        s_valid = bus.instr_valid_o;
        s_instr = bus.instr_o;
        s_pc    = bus.pc_instr_o;
        s_count = count_o;

        // Predict this cycle from the rules
        e_req     = !fl && !st && ((m_q.size() + int'(m_inflight)) < DEPTH);
        accept    = rv && m_inflight && !m_drop && !fl;
        resp      = '{pc: m_inflight_pc, instr: rdata};
        hv        = 1'b0;
        from_resp = 1'b0;
        head      = '{pc: 32'h0, instr: FETCH_NOP_INSTR};
        if (m_q.size() != 0) begin
            head = m_q[0];
            hv   = 1'b1;
        end else if (BYP && accept) begin
            head      = resp;
            hv        = 1'b1;
            from_resp = 1'b1;
        end

        check("req",   s_req,   e_req);
        check("addr",  s_addr,  e_req ? m_pc : 32'h0);
        check("valid", s_valid, hv);
        check("instr", s_instr, head.instr);
        check("pc",    s_pc,    head.pc);
        check("count", s_count, m_q.size());

        if (s_valid && rdy && !fl) pop_log.push_back(s_pc);

        // Advance the model past the clock edge
        if (fl) begin
            m_q.delete();
            m_drop     = m_inflight;
            m_inflight = 1'b0;
            m_pc       = fpc & ~32'd3;
        end else begin
            popped = hv && rdy;
            if (popped && !from_resp) void'(m_q.pop_front());
            if (accept && !(popped && from_resp)) m_q.push_back(resp);
            m_drop        = 1'b0;
            m_inflight    = e_req;
            m_inflight_pc = m_pc;
            if (e_req) m_pc = m_pc + 32'd4;
        end

        prev_req  = s_req;
        prev_addr = s_addr;
        @(negedge clk_i);
    endtask

    task automatic check_order(input string name, input logic [31:0] first);
        check({name, "_first"}, pop_log[0], first);
        for (int i = 1; i < pop_log.size(); i++)
            check(name, pop_log[i], pop_log[i-1] + 32'd4);
    endtask

    initial begin
        // Expected start-up stream with decode always ready
        for (int i = 0; i < 6; i++) begin
            tbl[i].rdy     = 1'b1;
            tbl[i].e_req   = 1'b1;
            tbl[i].e_addr  = RESET_PC + 32'(4 * i);
            tbl[i].e_valid = (i >= LAT);
            tbl[i].e_pc    = (i >= LAT) ? RESET_PC + 32'(4 * (i - LAT)) : 32'h0;
            tbl[i].e_instr = (i >= LAT) ? (tbl[i].e_pc ^ KEY) : FETCH_NOP_INSTR;
            tbl[i].e_count = (LAT == 2 && i >= 2) ? 1 : 0;
        end

        rst_i             = 1'b1;
        flush_i           = 1'b0;
        flush_pc_i        = '0;
        dma_stall_i       = 1'b0;
        bus.instr_ready_i = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        #1;
        check("rst_valid", bus.instr_valid_o, 1'b0);
        check("rst_instr", bus.instr_o, FETCH_NOP_INSTR);
        check("rst_pc",    bus.pc_instr_o, 32'h0);
        check("rst_req",   bus.imem_req_o, 1'b0);
        check("rst_count", count_o, 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();

        // Start-up stream from the table
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 32'h0, 1'b0, tbl[i].rdy, 1'b0);
            check("tbl_req",   s_req,   tbl[i].e_req);
            check("tbl_addr",  s_addr,  tbl[i].e_addr);
            check("tbl_valid", s_valid, tbl[i].e_valid);
            check("tbl_pc",    s_pc,    tbl[i].e_pc);
            check("tbl_instr", s_instr, tbl[i].e_instr);
            check("tbl_count", s_count, tbl[i].e_count);
        end

        // Back-pressure: queue saturates, requests stop, nothing lost on resume
        repeat (10) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("sat_count", s_count, DEPTH);
        check("sat_req",   s_req,   1'b0);
        repeat (12) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check_order("sat_order", RESET_PC);

        // Redirect while a request is in flight
        check("flush_setup_inflight", s_req, 1'b1);
        cycle(1'b1, 32'h1000_0102, 1'b0, 1'b1, 1'b0);
        pop_log.delete();
        for (int k = 1; k <= 3; k++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            if (k == 1) begin
                check("flush_req",  s_req,  1'b1);
                check("flush_addr", s_addr, 32'h1000_0100);
            end
            check("flush_valid", s_valid, (k >= 1 + LAT));
            check("flush_pc", s_pc,
                  (k >= 1 + LAT) ? 32'h1000_0100 + 32'(4 * (k - 1 - LAT)) : 32'h0);
        end

        // DMA stall: three-cycle request gap, order preserved
        repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("stall_setup_req", s_req, 1'b1);
        a0 = s_addr;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
            check("stall_req", s_req, 1'b0);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("stall_resume_req",  s_req,  1'b1);
        check("stall_resume_addr", s_addr, a0 + 32'd4);
        repeat (4) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check_order("stall_order", 32'h1000_0100);

        // Fetch address wraps past the top of the address space
        cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("wrap_addr_hi", s_addr, 32'hFFFF_FFFC);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("wrap_addr_lo", s_addr, 32'h0000_0000);
        repeat (4) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a cycle
        #2 rst_i = 1'b1;
        #1;
        check("arst_valid", bus.instr_valid_o, 1'b0);
        check("arst_instr", bus.instr_o, FETCH_NOP_INSTR);
        check("arst_pc",    bus.pc_instr_o, 32'h0);
        check("arst_req",   bus.imem_req_o, 1'b0);
        check("arst_addr",  bus.imem_addr_o, 32'h0);
        check("arst_count", count_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        for (int i = 0; i <= LAT; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            if (i == 0) check("arst_first_addr", s_addr, RESET_PC);
            check("arst_lat_valid", s_valid, (i >= LAT));
            check("arst_lat_pc", s_pc, (i >= LAT) ? RESET_PC : 32'h0);
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            bit          fl, st, rdy, spur;
            logic [31:0] fpc;
            fl   = ($urandom_range(0, 19) == 0);
            fpc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            st   = ($urandom_range(0, 9) == 0);
            rdy  = ($urandom_range(0, 3) != 0);
            spur = ($urandom_range(0, 7) == 0);
            cycle(fl, fpc, st, rdy, spur);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
